// File: rtl/disp_pkg.sv
// Shared definitions for the display message arbiter: message codes and FSM states.
package disp_pkg;

    localparam logic [1:0] MSG_NUM = 2'b00;
    localparam logic [1:0] MSG_OP  = 2'b01;
    localparam logic [1:0] MSG_VAL = 2'b10;
    localparam logic [1:0] MSG_ERR = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLoad = 2'b01,
        StHold = 2'b10
    } state_e;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder over the request vector.
module prio_enc #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    output logic            valid,
    output logic [IDXW-1:0] idx
);

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan from the top so the lowest set index is the one left standing.
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/disp_msg_arbiter.sv
// Fixed-priority arbiter sharing the seven-segment decoder write port among requesters,
// with a minimum on-screen hold time and optional preemption by requester 0.
module disp_msg_arbiter
    import disp_pkg::*;
#(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter bit          PREEMPT0    = 1'b1,
    localparam int unsigned IDXW       = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int unsigned CNTW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   ack,
    input  logic [2*NREQ-1:0] req_msg,
    input  logic [8*NREQ-1:0] req_bin,
    input  logic [NREQ-1:0]   req_sgn,
    input  logic [2*NREQ-1:0] req_dot,
    output logic [7:0]        bin,
    output logic              wr_enable,
    output logic              led0_sel,
    output logic [1:0]        msg,
    output logic              sgn,
    output logic [1:0]        dot,
    output logic              busy,
    output logic [IDXW-1:0]   owner
);

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              grant;
    logic              enc_valid;
    logic [IDXW-1:0]   enc_idx;

    logic [7:0]        bin_q;
    logic [1:0]        msg_q;
    logic              sgn_q;
    logic [1:0]        dot_q;
    logic              wr_q;
    logic              busy_q;
    logic [NREQ-1:0]   ack_q;
    logic [IDXW-1:0]   owner_q;

    prio_enc #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_prio_enc (
        .req   (req),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant   = 1'b0;
        case (state_q)
            StIdle: begin
                if (enc_valid) begin
                    grant   = 1'b1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = CNTW'(HOLD_CYCLES - 1);
                state_d = StHold;
            end
            StHold: begin
                // Preemption wins even on the last hold cycle; req[0] makes enc_idx zero.
                if (PREEMPT0 && req[0] && (owner_q != '0)) begin
                    grant   = 1'b1;
                    state_d = StLoad;
                end else if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bin_q   <= '0;
            msg_q   <= MSG_NUM;
            sgn_q   <= 1'b0;
            dot_q   <= '0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= grant;
            busy_q  <= (state_d != StIdle);
            ack_q   <= grant ? (NREQ'(1) << enc_idx) : '0;
            if (grant) begin
                owner_q <= enc_idx;
                bin_q   <= req_bin[8*enc_idx +: 8];
                msg_q   <= req_msg[2*enc_idx +: 2];
                sgn_q   <= req_sgn[enc_idx];
                dot_q   <= req_dot[2*enc_idx +: 2];
            end
        end
    end

    assign bin       = bin_q;
    assign msg       = msg_q;
    assign sgn       = sgn_q;
    assign dot       = dot_q;
    assign wr_enable = wr_q;
    assign led0_sel  = wr_q;
    assign busy      = busy_q;
    assign ack       = ack_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_disp_msg_arbiter.sv
// Bench for disp_msg_arbiter: two instances (preempting and non-preempting) on shared
// stimulus, checked against a countdown-based behavioural model of the display schedule.
module tb_disp_msg_arbiter;
    import disp_pkg::*;

    localparam int NI = 3;
    localparam int HI = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    req = '0;
    logic [5:0]    req_msg = '0;
    logic [23:0]   req_bin = '0;
    logic [2:0]    req_sgn = '0;
    logic [5:0]    req_dot = '0;

    logic [2:0]    o_ack   [2];
    logic [7:0]    o_bin   [2];
    logic          o_wr    [2];
    logic          o_led   [2];
    logic [1:0]    o_msg   [2];
    logic          o_sgn   [2];
    logic [1:0]    o_dot   [2];
    logic          o_busy  [2];
    logic [1:0]    o_owner [2];

    int checks = 0;
    int errors = 0;

    // Model: remaining busy cycles (LOAD + HOLD) and the currently displayed message.
    int         m_left [2];
    bit         m_load [2];
    int         m_own  [2];
    logic [7:0] m_bin  [2];
    logic [1:0] m_msg  [2];
    logic       m_sgn  [2];
    logic [1:0] m_dot  [2];

    disp_msg_arbiter #(.NREQ(NI), .HOLD_CYCLES(HI), .PREEMPT0(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(o_ack[0]), .req_msg(req_msg),
        .req_bin(req_bin), .req_sgn(req_sgn), .req_dot(req_dot), .bin(o_bin[0]),
        .wr_enable(o_wr[0]), .led0_sel(o_led[0]), .msg(o_msg[0]), .sgn(o_sgn[0]),
        .dot(o_dot[0]), .busy(o_busy[0]), .owner(o_owner[0])
    );

    disp_msg_arbiter #(.NREQ(NI), .HOLD_CYCLES(HI), .PREEMPT0(1'b0)) dut_np (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(o_ack[1]), .req_msg(req_msg),
        .req_bin(req_bin), .req_sgn(req_sgn), .req_dot(req_dot), .bin(o_bin[1]),
        .wr_enable(o_wr[1]), .led0_sel(o_led[1]), .msg(o_msg[1]), .sgn(o_sgn[1]),
        .dot(o_dot[1]), .busy(o_busy[1]), .owner(o_owner[1])
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [2:0] m_ack(int k);
        return m_load[k] ? 3'(1 << m_own[k]) : 3'b000;
    endfunction

    function automatic logic [20:0] model_vec(int k);
        return {m_ack(k), m_load[k], m_load[k], (m_left[k] > 0), 2'(m_own[k]),
                m_bin[k], m_msg[k], m_sgn[k], m_dot[k]};
    endfunction

    function automatic logic [20:0] dut_vec(int k);
        return {o_ack[k], o_wr[k], o_led[k], o_busy[k], o_owner[k],
                o_bin[k], o_msg[k], o_sgn[k], o_dot[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0; m_load[k] = 1'b0; m_own[k] = 0;
            m_bin[k] = '0; m_msg[k] = '0; m_sgn[k] = 1'b0; m_dot[k] = '0;
        end
    endtask

    task automatic model_advance();
        bit pre;
        int g;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_left[k] = 0; m_load[k] = 1'b0; m_own[k] = 0;
                m_bin[k] = '0; m_msg[k] = '0; m_sgn[k] = 1'b0; m_dot[k] = '0;
            end else begin
                pre = (k == 0) && req[0] && (m_own[k] != 0) && (m_left[k] > 0)
                      && (m_left[k] <= HI);
                if ((m_left[k] == 0 && req != 0) || pre) begin
                    g = 0;
                    for (int i = NI - 1; i >= 0; i--) if (req[i]) g = i;
                    m_own[k]  = g;
                    m_bin[k]  = req_bin[8*g +: 8];
                    m_msg[k]  = req_msg[2*g +: 2];
                    m_sgn[k]  = req_sgn[g];
                    m_dot[k]  = req_dot[2*g +: 2];
                    m_left[k] = HI + 1;
                    m_load[k] = 1'b1;
                end else begin
                    m_load[k] = 1'b0;
                    if (m_left[k] > 0) m_left[k]--;
                end
            end
        end
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] m, input logic [7:0] b,
                           input logic s, input logic [1:0] d);
        req[i]             = 1'b1;
        req_msg[2*i +: 2]  = m;
        req_bin[8*i +: 8]  = b;
        req_sgn[i]         = s;
        req_dot[2*i +: 2]  = d;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100 && (m_left[0] != 0 || m_left[1] != 0); c++) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_vec(k) !== 21'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got %h want 0", k, dut_vec(k));
            end
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int n;
        wait_idle();
        set_req(1, MSG_NUM, 8'd123, 1'b1, 2'd1);
        step();
        checks++;
        if ({o_wr[0], o_led[0], o_ack[0]} !== 5'b11_010) begin
            errors++;
            $display("FAIL single_load wr/led/ack got %b want 11010",
                     {o_wr[0], o_led[0], o_ack[0]});
        end
        checks++;
        if ({o_bin[0], o_sgn[0], o_dot[0], o_msg[0]} !== {8'd123, 1'b1, 2'd1, 2'b00}) begin
            errors++;
            $display("FAIL single_fields got bin=%0d sgn=%0b dot=%0d msg=%b want 123 1 1 00",
                     o_bin[0], o_sgn[0], o_dot[0], o_msg[0]);
        end
        req[1] = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && o_busy[0]; c++) begin
            n++;
            step();
        end
        checks++;
        if (n != HI + 1) begin
            errors++;
            $display("FAIL single_busy_len got %0d want %0d", n, HI + 1);
        end
    endtask

    task automatic test_simultaneous();
        int  n;
        bit  seen;
        wait_idle();
        set_req(1, MSG_OP, 8'd11, 1'b0, 2'd0);
        set_req(2, MSG_VAL, 8'd22, 1'b1, 2'd2);
        step();
        checks++;
        if (o_ack[0] !== 3'b010) begin
            errors++;
            $display("FAIL simul_first_ack got %b want 010", o_ack[0]);
        end
        req[1] = 1'b0;
        n = 0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            n++;
            seen = o_ack[0][2];
        end
        checks++;
        if (!seen || n != HI + 2) begin
            errors++;
            $display("FAIL simul_second_ack got delay %0d seen %0b want %0d", n, seen, HI + 2);
        end
        checks++;
        if (o_bin[0] !== 8'd22) begin
            errors++;
            $display("FAIL simul_second_bin got %0d want 22", o_bin[0]);
        end
        req[2] = 1'b0;
    endtask

    task automatic test_preempt();
        int  t;
        bit  seen;
        wait_idle();
        set_req(2, MSG_OP, 8'd77, 1'b0, 2'd2);
        step();
        checks++;
        if (o_ack[0] !== 3'b100 || o_ack[1] !== 3'b100) begin
            errors++;
            $display("FAIL preempt_owner2_ack got %b/%b want 100/100", o_ack[0], o_ack[1]);
        end
        req[2] = 1'b0;
        step(); step(); step();
        set_req(0, MSG_ERR, 8'd9, 1'b1, 2'd0);
        step();
        t = 1;
        checks++;
        if ({o_wr[0], o_msg[0], o_owner[0], o_ack[0]} !== {1'b1, 2'b11, 2'd0, 3'b001}) begin
            errors++;
            $display("FAIL preempt_load got wr=%0b msg=%b owner=%0d ack=%b want 1 11 0 001",
                     o_wr[0], o_msg[0], o_owner[0], o_ack[0]);
        end
        checks++;
        if ({o_busy[1], o_ack[1], o_owner[1]} !== {1'b1, 3'b000, 2'd2}) begin
            errors++;
            $display("FAIL nopreempt_hold got busy=%0b ack=%b owner=%0d want 1 000 2",
                     o_busy[1], o_ack[1], o_owner[1]);
        end
        seen = o_ack[1][0];
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            t++;
            seen = o_ack[1][0];
        end
        checks++;
        if (!seen || t != HI - 3 + 2) begin
            errors++;
            $display("FAIL nopreempt_ack0 got delay %0d seen %0b want %0d", t, seen, HI - 1);
        end
        req[0] = 1'b0;
        for (int c = 0; c < 60 && o_busy[0]; c++) begin
            step();
            t++;
        end
        checks++;
        if (t != HI + 2) begin
            errors++;
            $display("FAIL preempt_no_resume got idle at %0d want %0d", t, HI + 2);
        end
    endtask

    task automatic test_field_stability();
        int pulses;
        wait_idle();
        set_req(1, MSG_VAL, 8'd55, 1'b0, 2'd3);
        step();
        checks++;
        if (o_bin[0] !== 8'd55 || o_wr[0] !== 1'b1) begin
            errors++;
            $display("FAIL stable_load got bin=%0d wr=%0b want 55 1", o_bin[0], o_wr[0]);
        end
        req[1] = 1'b0;
        req_bin[15:8] = 8'd200;
        req_msg[3:2]  = MSG_OP;
        pulses = 0;
        for (int c = 0; c < HI + 4; c++) begin
            step();
            if (o_wr[0]) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL stable_wr_pulses got %0d extra want 0", pulses);
        end
        checks++;
        if (o_bin[0] !== 8'd55 || o_msg[0] !== MSG_VAL) begin
            errors++;
            $display("FAIL stable_fields got bin=%0d msg=%b want 55 10", o_bin[0], o_msg[0]);
        end
    endtask

    task automatic test_reset_mid_hold();
        wait_idle();
        set_req(1, MSG_NUM, 8'd66, 1'b0, 2'd1);
        step();
        req[1] = 1'b0;
        set_req(2, MSG_ERR, 8'd88, 1'b1, 2'd2);
        step(); step(); step(); step();
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_vec(k) !== 21'd0) begin
                errors++;
                $display("FAIL midhold_reset dut%0d got %h want 0", k, dut_vec(k));
            end
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({o_ack[0], o_wr[0], o_bin[0]} !== {3'b100, 1'b1, 8'd88}) begin
            errors++;
            $display("FAIL midhold_regrant got ack=%b wr=%0b bin=%0d want 100 1 88",
                     o_ack[0], o_wr[0], o_bin[0]);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_vec(k) !== model_vec(k)) begin
                errors++;
                $display("FAIL midhold_model dut%0d got %h want %h", k, dut_vec(k), model_vec(k));
            end
        end
        req[2] = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] acked;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NI; i++) begin
                if (!req[i] && $urandom_range(0, (i == 0) ? 15 : 3) == 0)
                    set_req(i, 2'($urandom), 8'($urandom), 1'($urandom), 2'($urandom));
                else if ($urandom_range(0, 7) == 0)
                    req_bin[8*i +: 8] = 8'($urandom);
            end
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dut_vec(k) !== model_vec(k)) begin
                    errors++;
                    $display("FAIL random_cycle%0d dut%0d got %h want %h",
                             c, k, dut_vec(k), model_vec(k));
                end
            end
            acked = m_ack(0);
            req = req & ~acked;
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_preempt();
        test_field_stability();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
